piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_pkg.sv | 14 +
 rtl/piso_bit_counter.sv | 37 +++
 rtl/piso_serializer.sv | 79 +++++++
 tb/tb_piso_serializer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
package piso_pkg;

    typedef logic [0:0] state_t;

    localparam state_t StIdle  = 1'b0;
    localparam state_t StShift = 1'b1;

    // Width of a counter that indexes n bits; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit index counter with enable, synchronous clear and terminal count at N-1.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_o
);

    localparam int unsigned W = cnt_width(N);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == W'(N - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shift register with valid/ready load and stallable
// serial side; a new word can load on the last-bit cycle with no bubble.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter bit          MSB_FIRST = 1'b0,
    parameter logic        FILL      = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_valid_i,
    output logic         load_ready_o,
    input  logic [N-1:0] parallel_in_i,
    input  logic         shift_en_i,
    output logic         serial_out_o,
    output logic         serial_valid_o,
    output logic         last_o,
    output logic         busy_o
);

    state_t       state_q, state_d;
    logic [N-1:0] sreg_q, sreg_d;
    logic         in_shift;
    logic         tc;
    logic         load;
    logic         step;

    assign in_shift = (state_q == StShift);
    assign step     = in_shift & shift_en_i;

    // Only combinational input-to-output path: ready opens on the consumed last bit.
    assign load_ready_o = ~reset & (~in_shift | (tc & shift_en_i));
    assign load         = load_valid_i & load_ready_o;

    piso_bit_counter #(
        .N (N)
    ) u_bit_counter (
        .clk   (clk),
        .reset (reset),
        .en_i  (step & ~tc),
        .clr_i (load | (step & tc)),
        .tc_o  (tc)
    );

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = StShift;
        end else if (step && tc) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        sreg_d = sreg_q;
        if (load) begin
            sreg_d = parallel_in_i;
        end else if (step) begin
            sreg_d = MSB_FIRST ? {sreg_q[N-2:0], FILL} : {FILL, sreg_q[N-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
        end
    end

    assign serial_out_o   = in_shift & (MSB_FIRST ? sreg_q[N-1] : sreg_q[0]);
    assign serial_valid_o = in_shift;
    assign busy_o         = in_shift;
    assign last_o         = in_shift & tc;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three configurations share one stimulus and are
// checked every cycle against a word/index model, plus literal sequence checks.
module tb_piso_serializer;

    logic       clk;
    logic       reset;
    logic       load_valid;
    logic       shift_en;
    logic [7:0] pin;
    logic       ready [3];
    logic       sout  [3];
    logic       sval  [3];
    logic       last  [3];
    logic       busy  [3];

    int vectors     = 0;
    int miscompares = 0;

    // Model state: current word, index of the bit on the wire, word active.
    logic [63:0] m_word [3];
    int          m_idx  [3];
    bit          m_act  [3];

    piso_serializer #(.N(8), .MSB_FIRST(1'b0), .FILL(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .load_valid_i(load_valid), .load_ready_o(ready[0]),
        .parallel_in_i(pin), .shift_en_i(shift_en), .serial_out_o(sout[0]),
        .serial_valid_o(sval[0]), .last_o(last[0]), .busy_o(busy[0])
    );

    piso_serializer #(.N(8), .MSB_FIRST(1'b1), .FILL(1'b0)) u_dut1 (
        .clk(clk), .reset(reset), .load_valid_i(load_valid), .load_ready_o(ready[1]),
        .parallel_in_i(pin), .shift_en_i(shift_en), .serial_out_o(sout[1]),
        .serial_valid_o(sval[1]), .last_o(last[1]), .busy_o(busy[1])
    );

    piso_serializer #(.N(2), .MSB_FIRST(1'b0), .FILL(1'b1)) u_dut2 (
        .clk(clk), .reset(reset), .load_valid_i(load_valid), .load_ready_o(ready[2]),
        .parallel_in_i(pin[1:0]), .shift_en_i(shift_en), .serial_out_o(sout[2]),
        .serial_valid_o(sval[2]), .last_o(last[2]), .busy_o(busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int n_of(input int k);
        return (k == 2) ? 2 : 8;
    endfunction

    function automatic logic exp_out(input int k);
        int pos;
        if (!m_act[k]) return 1'b0;
        pos = (k == 1) ? (n_of(k) - 1 - m_idx[k]) : m_idx[k];
        return m_word[k][pos];
    endfunction

    function automatic logic exp_last(input int k);
        return m_act[k] && (m_idx[k] == n_of(k) - 1);
    endfunction

    function automatic logic exp_ready(input int k);
        return !reset && (!m_act[k] || (exp_last(k) && shift_en));
    endfunction

    task automatic chk(input string nm, input int k, input logic [15:0] got,
                       input logic [15:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s [dut%0d] got %h want %h", nm, k, got, want);
        end
    endtask

    // Reference model: a word is a list of N bits emitted in order.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                m_act[k] <= 1'b0;
                m_idx[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (m_act[k] && shift_en) begin
                    if (m_idx[k] == n_of(k) - 1) m_act[k] <= 1'b0;
                    else m_idx[k] <= m_idx[k] + 1;
                end
                if (exp_ready(k) && load_valid) begin
                    m_word[k] <= 64'(pin) & ((64'd1 << n_of(k)) - 64'd1);
                    m_idx[k]  <= 0;
                    m_act[k]  <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk("serial_out", k, {15'd0, sout[k]}, {15'd0, exp_out(k)});
            chk("serial_valid", k, {15'd0, sval[k]}, {15'd0, m_act[k]});
            chk("busy", k, {15'd0, busy[k]}, {15'd0, m_act[k]});
            chk("last", k, {15'd0, last[k]}, {15'd0, exp_last(k)});
            chk("load_ready", k, {15'd0, ready[k]}, {15'd0, exp_ready(k)});
        end
    end

    task automatic idle_all();
        load_valid = 1'b0;
        shift_en   = 1'b1;
        repeat (20) @(posedge clk);
        #1;
    endtask

    // Offer a word for one cycle; returns at edge+1 after the transfer.
    task automatic load_word(input logic [7:0] w);
        load_valid = 1'b1;
        pin        = w;
        shift_en   = 1'b1;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
    endtask

    logic [15:0] cs, cl, cr, cv;

    initial begin
        reset      = 1'b1;
        load_valid = 1'b0;
        shift_en   = 1'b0;
        pin        = 8'h00;
        for (int k = 0; k < 3; k++) begin
            m_act[k]  = 1'b0;
            m_idx[k]  = 0;
            m_word[k] = '0;
        end
        #2;
        for (int k = 0; k < 3; k++) begin
            chk("rst_ready", k, {15'd0, ready[k]}, 16'd0);
            chk("rst_valid", k, {15'd0, sval[k]}, 16'd0);
            chk("rst_out", k, {15'd0, sout[k]}, 16'd0);
            chk("rst_busy", k, {15'd0, busy[k]}, 16'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        idle_all();

        // A5 LSB-first and MSB-first both read 1,0,1,0,0,1,0,1.
        load_word(8'hA5);
        cs = '0; cl = '0; cv = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cs[i] = sout[0];
            cl[i] = last[0];
            cv[i] = sout[1];
            @(posedge clk);
            #1;
        end
        chk("a5_lsb_bits", 0, cs, 16'h00A5);
        chk("a5_last", 0, cl, 16'h0080);
        chk("a5_msb_bits", 1, cv, 16'h00A5);
        @(negedge clk);
        #1;
        chk("a5_idle_after", 0, {15'd0, busy[0]}, 16'd0);
        @(posedge clk);
        #1;
        idle_all();

        // FF then 00 back-to-back with load_valid held.
        load_valid = 1'b1;
        pin        = 8'hFF;
        shift_en   = 1'b1;
        @(posedge clk);
        #1;
        pin = 8'h00;
        cs = '0; cv = '0; cr = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            cs[i] = sout[0];
            cv[i] = sval[0];
            cr[i] = ready[0];
            @(posedge clk);
            #1;
            if (i == 7) load_valid = 1'b0;
        end
        chk("b2b_bits", 0, cs, 16'h00FF);
        chk("b2b_valid", 0, cv, 16'hFFFF);
        chk("b2b_ready", 0, cr, 16'h8080);
        idle_all();

        // 81 with a three-cycle stall after bit 2.
        load_word(8'h81);
        cs = '0; cl = '0;
        for (int i = 0; i < 11; i++) begin
            shift_en = (i < 3) || (i > 5);
            @(negedge clk);
            cs[i] = sout[0];
            cl[i] = last[0];
            @(posedge clk);
            #1;
        end
        chk("stall_bits", 0, cs, 16'h0401);
        chk("stall_last", 0, cl, 16'h0400);
        idle_all();

        // Reset in the middle of 3C, then C3 from bit 0.
        load_word(8'h3C);
        cs = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cs[i] = sout[0];
            if (i < 4) begin
                @(posedge clk);
                #1;
            end
        end
        chk("3c_head", 0, cs, 16'h001C);
        #1;
        reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("abort_ready", k, {15'd0, ready[k]}, 16'd0);
            chk("abort_valid", k, {15'd0, sval[k]}, 16'd0);
            chk("abort_out", k, {15'd0, sout[k]}, 16'd0);
            chk("abort_last", k, {15'd0, last[k]}, 16'd0);
        end
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("release_ready", 0, {15'd0, ready[0]}, 16'd1);
        @(posedge clk);
        #1;
        load_word(8'hC3);
        cs = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cs[i] = sout[0];
            @(posedge clk);
            #1;
        end
        chk("c3_bits", 0, cs, 16'h00C3);
        idle_all();

        // N=2: held load_valid is ignored until the last-bit cycle.
        load_valid = 1'b1;
        pin        = 8'h02;
        shift_en   = 1'b1;
        @(posedge clk);
        #1;
        pin = 8'h01;
        cs = '0; cl = '0; cr = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cs[i] = sout[2];
            cl[i] = last[2];
            cr[i] = ready[2];
            @(posedge clk);
            #1;
            if (i == 1) load_valid = 1'b0;
        end
        chk("n2_bits", 2, cs, 16'h0006);
        chk("n2_last", 2, cl, 16'h000A);
        chk("n2_ready", 2, cr, 16'h000A);
        idle_all();

        // Randomized traffic with occasional asynchronous reset pulses.
        for (int c = 0; c < 3000; c++) begin
            load_valid = 1'($urandom_range(0, 1));
            shift_en   = ($urandom_range(0, 3) != 0);
            pin        = 8'($urandom);
            @(posedge clk);
            #1;
            if ($urandom_range(0, 199) == 0) begin
                #2;
                reset = 1'b1;
                @(posedge clk);
                #1;
                reset = 1'b0;
            end
        end

        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
